// File: rtl/flash_read_arbiter_if.sv
// Bundle of both requester ports, the shared byte-return path and the
// flash reader link used by flash_read_arbiter.
interface flash_read_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 8
);
  logic              r0_req;
  logic              r1_req;
  logic [ADDR_W-1:0] r0_addr;
  logic [ADDR_W-1:0] r1_addr;
  logic [LEN_W-1:0]  r0_len;
  logic [LEN_W-1:0]  r1_len;
  logic              r0_ack;
  logic              r1_ack;
  logic              r0_valid;
  logic              r1_valid;
  logic              r0_ready;
  logic              r1_ready;
  logic [7:0]        out_data;
  logic              out_last;
  logic              grant;
  logic              busy;
  logic              fr_read;
  logic [ADDR_W-1:0] fr_addr;
  logic              fr_ready;
  logic [7:0]        fr_data;

  // Arbiter side.
  modport slave (
    input  r0_req, r1_req, r0_addr, r1_addr, r0_len, r1_len,
    input  r0_ready, r1_ready, fr_ready, fr_data,
    output r0_ack, r1_ack, r0_valid, r1_valid, out_data, out_last,
    output grant, busy, fr_read, fr_addr
  );

  // Requesters plus flash reader side.
  modport master (
    output r0_req, r1_req, r0_addr, r1_addr, r0_len, r1_len,
    output r0_ready, r1_ready, fr_ready, fr_data,
    input  r0_ack, r1_ack, r0_valid, r1_valid, out_data, out_last,
    input  grant, busy, fr_read, fr_addr
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Two-requester burst arbiter in front of a single-byte flash reader:
// round-robin per burst, one flash read per byte, bytes returned over valid/ready.
module flash_read_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int LEN_W        = 8,
  parameter int FLUSH_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  flash_read_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [LEN_W:0] ONE_LEFT = (LEN_W+1)'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W:0]    remaining_q, remaining_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              busy_q, busy_d;
  logic              out_last_q, out_last_d;
  logic              fr_read_q, fr_read_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        valid_q, valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [ADDR_W-1:0] fr_addr_q, fr_addr_d;

  logic [1:0]        req;
  logic [1:0]        ready;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [LEN_W-1:0]  req_len   [2];
  logic [LEN_W:0]    req_bytes [2];
  logic              pick;

  assign req         = {bus.r1_req, bus.r0_req};
  assign ready       = {bus.r1_ready, bus.r0_ready};
  assign req_addr[0] = bus.r0_addr;
  assign req_addr[1] = bus.r1_addr;
  assign req_len[0]  = bus.r0_len;
  assign req_len[1]  = bus.r1_len;

  // A zero length field stands for the full 2^LEN_W byte burst.
  for (genvar gi = 0; gi < 2; gi++) begin : g_len
    assign req_bytes[gi] = (req_len[gi] == '0) ? {1'b1, {LEN_W{1'b0}}}
                                                : {1'b0, req_len[gi]};
  end

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    out_last_d   = out_last_q;
    fr_read_d    = 1'b0;
    ack_d        = 2'b00;
    valid_d      = valid_q;
    out_data_d   = out_data_q;
    fr_addr_d    = fr_addr_q;
    pick         = 1'b0;

    case (state_q)
      // The reader has no reset and may still deliver a stale byte here.
      S_FLUSH: begin
        if (flush_cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (req != 2'b00) begin
          pick        = (req == 2'b11) ? ~last_grant_q : req[1];
          grant_d     = pick;
          cur_addr_d  = req_addr[pick];
          remaining_d = req_bytes[pick];
          ack_d[pick] = 1'b1;
          busy_d      = 1'b1;
          fr_read_d   = 1'b1;
          fr_addr_d   = req_addr[pick];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fr_ready) begin
          out_data_d       = bus.fr_data;
          out_last_d       = (remaining_q == ONE_LEFT);
          valid_d[grant_q] = 1'b1;
          state_d          = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ready[grant_q]) begin
          valid_d     = 2'b00;
          cur_addr_d  = cur_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (out_last_q) begin
            last_grant_d = grant_q;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            fr_read_d = 1'b1;
            fr_addr_d = cur_addr_q + 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      default: begin
        state_d = S_FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_FLUSH;
      flush_cnt_q  <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      busy_q       <= 1'b0;
      out_last_q   <= 1'b0;
      fr_read_q    <= 1'b0;
      ack_q        <= 2'b00;
      valid_q      <= 2'b00;
      out_data_q   <= '0;
      fr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      out_last_q   <= out_last_d;
      fr_read_q    <= fr_read_d;
      ack_q        <= ack_d;
      valid_q      <= valid_d;
      out_data_q   <= out_data_d;
      fr_addr_q    <= fr_addr_d;
    end
  end

  assign bus.r0_ack   = ack_q[0];
  assign bus.r1_ack   = ack_q[1];
  assign bus.r0_valid = valid_q[0];
  assign bus.r1_valid = valid_q[1];
  assign bus.out_data = out_data_q;
  assign bus.out_last = out_last_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.fr_read  = fr_read_q;
  assign bus.fr_addr  = fr_addr_q;

endmodule
